// File: rtl/misao_memsys_if.sv
// misao_memsys_if
//   Bundles the core memory port and the boot-loader stream between the
//   misao core side (master) and the memory subsystem (slave).
//
//   Core port : mem_enable_read, mem_enable_write, mem_addr[14:0],
//               mem_data_out[7:0] (core write data), mem_data_in[7:0]
//               (read data back to the core, combinational).
//   Loader    : load_valid, load_data[7:0], load_last, load_ready.
//
//   Handshake: a loader beat transfers on a rising clk edge where
//   load_valid && load_ready are both high. The source holds load_data and
//   load_last stable while load_valid is high and the beat is not yet
//   accepted; load_ready does not depend on load_valid.
interface misao_memsys_if;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_last;

  modport master (
    output mem_enable_read, mem_enable_write, mem_addr, mem_data_out,
    output load_valid, load_data, load_last,
    input  mem_data_in, load_ready
  );

  modport slave (
    input  mem_enable_read, mem_enable_write, mem_addr, mem_data_out,
    input  load_valid, load_data, load_last,
    output mem_data_in, load_ready
  );
endinterface

// File: rtl/misao_memsys.sv
// misao_memsys
//   Memory subsystem behind the misao core: byte RAM, a 5-byte MMIO window
//   (GPIO out/in, 16-bit free-running timer with hi-byte snapshot, status)
//   and a streaming boot loader that fills RAM from address 0 while the core
//   is held in reset.
//
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     bus         : misao_memsys_if.slave (core port + loader stream)
//     core_rst    : registered reset to the core, high while loading
//     gpio_in     : asynchronous external inputs (2-flop synchronised)
//     gpio_out    : GPIO output register
//     dbg_state   : current FSM state (0 = LOAD, 1 = RUN)
module misao_memsys #(
  parameter int          RAM_AW    = 8,
  parameter logic [14:0] MMIO_BASE = 15'h7FF0
) (
  input  logic               clk,
  input  logic               rst,
  misao_memsys_if.slave      bus,
  output logic               core_rst,
  input  logic [7:0]         gpio_in,
  output logic [7:0]         gpio_out,
  output logic               dbg_state
);

  localparam int RAM_SIZE = 1 << RAM_AW;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               core_rst_q, core_rst_d;
  logic               load_ready_q, load_ready_d;
  logic [RAM_AW-1:0]  load_addr_q, load_addr_d;
  logic [7:0]         gpio_out_q, gpio_out_d;
  logic [15:0]        tmr_q, tmr_d;
  logic [7:0]         snap_q, snap_d;
  logic [7:0]         sync1_q, sync1_d;
  logic [7:0]         sync2_q, sync2_d;
  logic [1:0]         status_q, status_d;

  logic [7:0]         ram [RAM_SIZE];

  logic               ram_we;
  logic [RAM_AW-1:0]  ram_waddr;
  logic [7:0]         ram_wdata;

  logic               is_run;
  logic               core_rd, core_wr;
  logic               ram_hit;
  logic [RAM_AW-1:0]  ram_idx;
  logic               sel_gpo, sel_gpi, sel_tlo, sel_thi, sel_st;
  logic               load_fire;
  logic               tmr_clr;
  logic               ovf_set, wrap_set;
  logic [1:0]         st_clr;
  logic [7:0]         rd_data;

  // Address decode. RAM is selected only when all upper address bits are
  // zero; each MMIO register matches on the full 15-bit address.
  assign is_run  = (state_q == ST_RUN);
  assign core_rd = is_run && bus.mem_enable_read;
  assign core_wr = is_run && bus.mem_enable_write;
  assign ram_hit = (bus.mem_addr[14:RAM_AW] == '0);
  assign ram_idx = bus.mem_addr[RAM_AW-1:0];
  assign sel_gpo = (bus.mem_addr == MMIO_BASE);
  assign sel_gpi = (bus.mem_addr == MMIO_BASE + 15'd1);
  assign sel_tlo = (bus.mem_addr == MMIO_BASE + 15'd2);
  assign sel_thi = (bus.mem_addr == MMIO_BASE + 15'd3);
  assign sel_st  = (bus.mem_addr == MMIO_BASE + 15'd4);

  assign load_fire = bus.load_valid && load_ready_q;

  // Combinational read path; a same-cycle write only lands at the edge, so a
  // simultaneous read sees the old value.
  always_comb begin
    rd_data = 8'h00;
    if (core_rd) begin
      if (ram_hit)      rd_data = ram[ram_idx];
      else if (sel_gpo) rd_data = gpio_out_q;
      else if (sel_gpi) rd_data = sync2_q;
      else if (sel_tlo) rd_data = tmr_q[7:0];
      else if (sel_thi) rd_data = snap_q;
      else if (sel_st)  rd_data = {6'b0, status_q};
    end
  end

  // FSM, loader and the single RAM write port.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    ovf_set     = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = ram_idx;
    ram_wdata   = bus.mem_data_out;
    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          ram_we      = 1'b1;
          ram_waddr   = load_addr_q;
          ram_wdata   = bus.load_data;
          load_addr_d = load_addr_q + RAM_AW'(1);
          ovf_set     = (load_addr_q == '1);
          if (bus.load_last) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_we = core_wr && ram_hit;
      end
      default: state_d = ST_LOAD;
    endcase
    // Outputs are registered from the next state so core_rst drops on the
    // very edge that enters RUN.
    core_rst_d   = (state_d != ST_RUN);
    load_ready_d = (state_d == ST_LOAD);
  end

  // MMIO registers and timer.
  always_comb begin
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
    gpio_out_d = (core_wr && sel_gpo) ? bus.mem_data_out : gpio_out_q;
    snap_d     = (core_rd && sel_tlo) ? tmr_q[15:8] : snap_q;
    // A timer write beats the increment, so it also suppresses a wrap event.
    tmr_clr    = core_wr && sel_tlo;
    wrap_set   = is_run && !tmr_clr && (tmr_q == 16'hFFFF);
    if (tmr_clr)     tmr_d = 16'h0000;
    else if (is_run) tmr_d = tmr_q + 16'd1;
    else             tmr_d = tmr_q;
    // Write-1-to-clear, with a same-cycle set event winning.
    st_clr   = (core_wr && sel_st) ? bus.mem_data_out[1:0] : 2'b00;
    status_d = (status_q & ~st_clr) | {wrap_set, ovf_set};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      core_rst_q   <= 1'b1;
      load_ready_q <= 1'b1;
      load_addr_q  <= '0;
      gpio_out_q   <= 8'h00;
      tmr_q        <= 16'h0000;
      snap_q       <= 8'h00;
      sync1_q      <= 8'h00;
      sync2_q      <= 8'h00;
      status_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      core_rst_q   <= core_rst_d;
      load_ready_q <= load_ready_d;
      load_addr_q  <= load_addr_d;
      gpio_out_q   <= gpio_out_d;
      tmr_q        <= tmr_d;
      snap_q       <= snap_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      status_q     <= status_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign bus.mem_data_in = rd_data;
  assign bus.load_ready  = load_ready_q;
  assign core_rst        = core_rst_q;
  assign gpio_out        = gpio_out_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_misao_memsys.sv
// tb_misao_memsys
//   Randomised bench for misao_memsys against a behavioural model of the
//   memory map (byte array, register variables, integer timer).
module tb_misao_memsys;

  logic       clk;
  logic       rst;
  logic       core_rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       dbg_state;

  misao_memsys_if bus();

  misao_memsys #(.RAM_AW(8), .MMIO_BASE(15'h7FF0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [256];
  bit          m_run;
  int          m_laddr;
  logic [7:0]  m_gpio;
  int          m_tmr;
  logic [7:0]  m_snap;
  logic [1:0]  m_status;
  logic [7:0]  gin_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run    = 1'b0;
      m_laddr  = 0;
      m_gpio   = 8'h00;
      m_tmr    = 0;
      m_snap   = 8'h00;
      m_status = 2'b00;
      gin_q    = '{8'h00, 8'h00};
    end else begin
      gin_q.push_back(gpio_in);
      void'(gin_q.pop_front());
      if (!m_run) begin
        if (bus.load_valid) begin
          m_ram[m_laddr] = bus.load_data;
          if (m_laddr == 255) m_status[0] = 1'b1;
          m_laddr = (m_laddr + 1) % 256;
          if (bus.load_last) m_run = 1'b1;
        end
      end else begin
        logic [1:0] clr;
        bit tclr;
        clr  = 2'b00;
        tclr = 1'b0;
        if (bus.mem_enable_read && bus.mem_addr == 15'h7FF2) m_snap = 8'(m_tmr / 256);
        if (bus.mem_enable_write) begin
          if (bus.mem_addr < 15'd256)        m_ram[bus.mem_addr[7:0]] = bus.mem_data_out;
          else if (bus.mem_addr == 15'h7FF0) m_gpio = bus.mem_data_out;
          else if (bus.mem_addr == 15'h7FF2) tclr = 1'b1;
          else if (bus.mem_addr == 15'h7FF4) clr = bus.mem_data_out[1:0];
        end
        m_status = m_status & ~clr;
        if (tclr) m_tmr = 0;
        else begin
          m_tmr = m_tmr + 1;
          if (m_tmr == 65536) begin
            m_tmr = 0;
            m_status[1] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] model_read(input logic r, input logic [14:0] a);
    if (!m_run || !r) return 8'h00;
    if (a < 15'd256) return m_ram[a[7:0]];
    case (a)
      15'h7FF0: return m_gpio;
      15'h7FF1: return gin_q[0];
      15'h7FF2: return 8'(m_tmr % 256);
      15'h7FF3: return m_snap;
      15'h7FF4: return {6'b0, m_status};
      default:  return 8'h00;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
    bus.mem_addr         = 15'h0;
    bus.mem_data_out     = 8'h00;
    bus.load_valid       = 1'b0;
    bus.load_data        = 8'h00;
    bus.load_last        = 1'b0;
  endtask

  // One core cycle: drive strobes, compare read data with the model, clock.
  task automatic core_access(input logic r, input logic w, input logic [14:0] a,
                             input logic [7:0] d, input string tag);
    bus.mem_enable_read  = r;
    bus.mem_enable_write = w;
    bus.mem_addr         = a;
    bus.mem_data_out     = d;
    #1;
    exp_q.push_back(model_read(r, a));
    check(tag, {8'h00, bus.mem_data_in}, {8'h00, exp_q.pop_front()});
    tick();
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
  endtask

  // Read with a fixed expected value derived from the test scenario.
  task automatic read_const(input logic [14:0] a, input logic [7:0] exp, input string tag);
    bus.mem_enable_read = 1'b1;
    bus.mem_addr        = a;
    #1;
    check(tag, {8'h00, bus.mem_data_in}, {8'h00, exp});
    tick();
    bus.mem_enable_read = 1'b0;
  endtask

  // Present one loader beat with valid held; caller drops valid afterwards.
  task automatic load_byte(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    check("load_ready", {15'h0, bus.load_ready}, {15'h0, !m_run});
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0]  lb [257];
  logic [14:0] ra;
  int          sel;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    gpio_in = 8'h00;
    rst     = 1'b1;
    idle_inputs();
    tick();
    check("rst_core_rst",   {15'h0, core_rst}, 16'h0001);
    check("rst_load_ready", {15'h0, bus.load_ready}, 16'h0001);
    check("rst_gpio_out",   {8'h00, gpio_out}, 16'h0000);
    check("rst_state",      {15'h0, dbg_state}, 16'h0000);
    tick();
    rst = 1'b0;

    // Loader stream 00,18,4E with valid held high.
    load_byte(8'h00, 1'b0);
    load_byte(8'h18, 1'b0);
    check("core_rst_before_last", {15'h0, core_rst}, 16'h0001);
    load_byte(8'h4E, 1'b1);
    check("core_rst_after_last", {15'h0, core_rst}, 16'h0000);
    check("load_ready_run",      {15'h0, bus.load_ready}, 16'h0000);
    check("state_run",           {15'h0, dbg_state}, 16'h0001);
    bus.load_data = 8'hFF;
    bus.load_last = 1'b0;
    tick();
    tick();
    bus.load_valid = 1'b0;
    read_const(15'h0000, 8'h00, "ld_ram0");
    read_const(15'h0001, 8'h18, "ld_ram1");
    read_const(15'h0002, 8'h4E, "ld_ram2");

    // Core RAM.
    core_access(1'b0, 1'b1, 15'h0080, 8'h05, "wr_80");
    read_const(15'h0080, 8'h05, "rd_80");
    bus.mem_addr = 15'h0080;
    #1;
    check("rd_disabled", {8'h00, bus.mem_data_in}, 16'h0000);
    tick();
    core_access(1'b0, 1'b1, 15'h0100, 8'h77, "wr_100");
    read_const(15'h0100, 8'h00, "rd_100");
    read_const(15'h0000, 8'h00, "ram0_intact");

    // MMIO GPIO.
    core_access(1'b0, 1'b1, 15'h7FF0, 8'hA5, "wr_gpo");
    check("gpio_out_a5", {8'h00, gpio_out}, 16'h00A5);
    read_const(15'h7FF0, 8'hA5, "rd_gpo");
    gpio_in = 8'h3C;
    read_const(15'h7FF1, 8'h00, "gpi_lat0");
    read_const(15'h7FF1, 8'h00, "gpi_lat1");
    read_const(15'h7FF1, 8'h3C, "gpi_lat2");
    read_const(15'h7FF5, 8'h00, "rd_7ff5");

    // Timer: atomic 16-bit read.
    core_access(1'b0, 1'b1, 15'h7FF2, 8'h00, "tmr_clr_a");
    repeat (16'h1234) tick();
    read_const(15'h7FF2, 8'h34, "tmr_lo_1234");
    read_const(15'h7FF3, 8'h12, "tmr_hi_1234");
    core_access(1'b0, 1'b1, 15'h7FF2, 8'h00, "tmr_clr_b");
    repeat (16'h12FF) tick();
    read_const(15'h7FF2, 8'hFF, "tmr_lo_12ff");
    read_const(15'h7FF3, 8'h12, "tmr_hi_12ff");

    // Timer wrap and W1C status.
    core_access(1'b0, 1'b1, 15'h7FF2, 8'h00, "tmr_clr_c");
    repeat (16'hFFFF) tick();
    read_const(15'h7FF4, 8'h00, "status_prewrap");
    read_const(15'h7FF4, 8'h02, "status_wrap");
    core_access(1'b0, 1'b1, 15'h7FF4, 8'h00, "st_w0");
    read_const(15'h7FF4, 8'h02, "status_w0_keeps");
    core_access(1'b0, 1'b1, 15'h7FF4, 8'h02, "st_w1c");
    read_const(15'h7FF4, 8'h00, "status_cleared");

    // Fill RAM so every byte is known to the model, then random traffic.
    for (int i = 0; i < 256; i++)
      core_access(1'b0, 1'b1, 15'(i), 8'($urandom_range(0, 255)), "fill");
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    ra = 15'($urandom_range(0, 255));
        2:       ra = 15'($urandom_range(16'h7FEF, 16'h7FF6));
        default: ra = 15'($urandom_range(256, 16'h7FEE));
      endcase
      gpio_in = 8'($urandom_range(0, 255));
      core_access(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ra,
                  8'($urandom_range(0, 255)), "rand_rd");
      check("rand_gpio_out", {8'h00, gpio_out}, {8'h00, m_gpio});
      check("rand_core_rst", {15'h0, core_rst}, {15'h0, !m_run});
    end
    core_access(1'b0, 1'b1, 15'h7FF0, 8'h5A, "wr_gpo_b");

    // Reset mid-load after 3 bytes.
    do_reset();
    for (int i = 0; i < 3; i++) load_byte(8'($urandom_range(0, 255)), 1'b0);
    bus.load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_core_rst",   {15'h0, core_rst}, 16'h0001);
    check("midrst_load_ready", {15'h0, bus.load_ready}, 16'h0001);
    check("midrst_gpio_out",   {8'h00, gpio_out}, 16'h0000);
    tick();
    rst = 1'b0;

    // Overflow: 257 bytes, last one wraps onto RAM[0].
    for (int i = 0; i < 257; i++) lb[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 257; i++) load_byte(lb[i], (i == 256));
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    check("ovf_core_rst", {15'h0, core_rst}, 16'h0000);
    read_const(15'h0000, lb[256], "ovf_ram0");
    read_const(15'h0001, lb[1],   "ovf_ram1");
    read_const(15'h00FF, lb[255], "ovf_ramff");
    read_const(15'h7FF4, 8'h01,   "ovf_status");
    for (int i = 0; i < 20; i++)
      core_access(1'b1, 1'b0, 15'($urandom_range(0, 255)), 8'h00, "post_ovf_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
